// File: rtl/sfr_gpio_bank.sv
// Memory-mapped GPIO SFR bank: per port OUT, DIR, IN and edge FLAG registers.
// Define SFR_GPIO_IRQ_EN to build the FLAG/edge-detect/IRQ logic; otherwise r=3 reads 0.
module sfr_gpio_bank #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned BASE_ADDR = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           addr,
    input  logic                        mw,
    input  logic                        mr,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic                        ram_en,
    input  logic [N_PORTS*DATA_W-1:0]   pin_in,
    output logic [N_PORTS*DATA_W-1:0]   pin_out,
    output logic [N_PORTS*DATA_W-1:0]   pin_oe,
    output logic                        irq
);

    localparam longint unsigned WinEnd = longint'(BASE_ADDR) + 4 * longint'(N_PORTS);

    if (ADDR_W < 3 || ADDR_W > 32 || N_PORTS < 1 || N_PORTS > 16 ||
        WinEnd > (64'd1 << ADDR_W)) begin : g_bad_cfg
        $error("sfr_gpio_bank: SFR window does not fit the address space");
    end

    localparam logic [ADDR_W:0] BaseExt = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] WinSize = (ADDR_W+1)'(4 * N_PORTS);

    typedef logic [N_PORTS-1:0][DATA_W-1:0] bank_t;

    logic [ADDR_W:0]   off_ext;
    logic              in_win;
    logic [1:0]        reg_sel;
    logic [ADDR_W-3:0] port_idx;

    bank_t out_q, out_d;
    bank_t dir_q, dir_d;
    bank_t sync1_q, sync2_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Below BASE_ADDR the subtraction borrows into the extra MSB.
    assign off_ext  = {1'b0, addr} - BaseExt;
    assign in_win   = ~off_ext[ADDR_W] && (off_ext < WinSize);
    assign reg_sel  = off_ext[1:0];
    assign port_idx = off_ext[ADDR_W-1:2];
    assign ram_en   = ~in_win;

`ifdef SFR_GPIO_IRQ_EN
    bank_t dly_q;
    bank_t flag_q, flag_d;
    logic  irq_q;
`endif

    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        rdata_d = '0;
`ifdef SFR_GPIO_IRQ_EN
        // Rising-edge set takes priority over a same-cycle write-1-to-clear.
        flag_d  = flag_q;
`endif
        for (int i = 0; i < int'(N_PORTS); i++) begin
`ifdef SFR_GPIO_IRQ_EN
            if (mw && in_win && port_idx == (ADDR_W-2)'(i) && reg_sel == 2'd3) begin
                flag_d[i] = flag_d[i] & ~wdata;
            end
            flag_d[i] = flag_d[i] | (sync2_q[i] & ~dly_q[i]);
`endif
            if (in_win && port_idx == (ADDR_W-2)'(i)) begin
                if (mw) begin
                    case (reg_sel)
                        2'd0:    out_d[i] = wdata;
                        2'd1:    dir_d[i] = wdata;
                        default: ;
                    endcase
                end
                if (mr) begin
                    case (reg_sel)
                        2'd0:    rdata_d = out_q[i];
                        2'd1:    rdata_d = dir_q[i];
                        2'd2:    rdata_d = sync2_q[i];
`ifdef SFR_GPIO_IRQ_EN
                        default: rdata_d = flag_q[i];
`else
                        default: rdata_d = '0;
`endif
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            dir_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            rdata_q <= rdata_d;
        end
    end

`ifdef SFR_GPIO_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q  <= '0;
            flag_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            dly_q  <= sync2_q;
            flag_q <= flag_d;
            irq_q  <= |flag_q;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign rdata   = rdata_q;
    assign pin_out = out_q;
    assign pin_oe  = dir_q;

endmodule
